// File: rtl/reg_bank_pkg.sv
// Shared encodings and types for the reg_bank register file.
// Used by reg_bank, reg_bank_if and incdec8.
package reg_bank_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_CLR  = 3'b100;
    localparam logic [2:0] OP_SWAP = 3'b101;

    // The reg_sel code doubles as the index into the register array.
    localparam logic [1:0] SEL_B = 2'b00;
    localparam logic [1:0] SEL_C = 2'b01;
    localparam logic [1:0] SEL_D = 2'b10;
    localparam logic [1:0] SEL_A = 2'b11;

    typedef struct packed {
        logic zero;
        logic carry;
    } flags_t;

    function automatic logic is_zero(input data_t v);
        return (v == '0);
    endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Command and status bundle between a controller (master) and reg_bank (slave).
interface reg_bank_if;
    import reg_bank_pkg::*;

    logic       wr_en;
    logic [2:0] op;
    logic [1:0] reg_sel;
    data_t      din;
    data_t      Aout;
    data_t      Bout;
    data_t      Cout;
    data_t      Dout;
    logic       zero;
    logic       carry;
    logic       busy;

    modport master (
        output wr_en, op, reg_sel, din,
        input  Aout, Bout, Cout, Dout, zero, carry, busy
    );

    modport slave (
        input  wr_en, op, reg_sel, din,
        output Aout, Bout, Cout, Dout, zero, carry, busy
    );

endinterface

// File: rtl/reg_bank_incdec8.sv
// Combinational 8-bit increment/decrement; carry is the carry out (inc)
// or the borrow out (dec).
module incdec8
    import reg_bank_pkg::*;
(
    input  data_t a,
    input  logic  dec,
    output data_t y,
    output logic  carry
);

    localparam logic [DATA_W:0] ONE = 1;

    logic [DATA_W:0] sum;

    // One extra bit catches FF->00 on increment and 00->FF on decrement.
    assign sum   = dec ? ({1'b0, a} - ONE) : ({1'b0, a} + ONE);
    assign y     = sum[DATA_W-1:0];
    assign carry = sum[DATA_W];

endmodule

// File: rtl/reg_bank.sv
// Four 8-bit registers (A/B/C/D) with LOAD/INC/DEC/CLR and a single write port.
// Define REG_BANK_SWAP_EN to build in the two-cycle SWAP with register A.
module reg_bank
    import reg_bank_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    reg_bank_if.slave bus
);

    data_t      regs [4];
    data_t      sel_val;
    data_t      wr_data;
    data_t      id_y;
    logic [1:0] wr_idx;
    logic       wr_do;
    logic       flag_do;
    logic       id_carry;
    logic       id_dec;
    logic       cmd_ok;
    flags_t     flags;
    flags_t     flags_nxt;

`ifdef REG_BANK_SWAP_EN
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWAP2 = 1'b1;

    logic [0:0] state;
    data_t      tmp;
    logic [1:0] swap_sel;
    logic       swap_go;

    assign cmd_ok = (state == ST_IDLE);
`else
    assign cmd_ok = 1'b1;
`endif

    assign sel_val = regs[bus.reg_sel];
    assign id_dec  = (bus.op == OP_DEC);

    incdec8 u_incdec (
        .a     (sel_val),
        .dec   (id_dec),
        .y     (id_y),
        .carry (id_carry)
    );

    // Decode the command into the single write port plus an optional flag update.
    always_comb begin
        wr_do     = 1'b0;
        wr_idx    = bus.reg_sel;
        wr_data   = bus.din;
        flag_do   = 1'b0;
        flags_nxt = flags;
`ifdef REG_BANK_SWAP_EN
        swap_go   = 1'b0;
`endif
        if (bus.wr_en && cmd_ok) begin
            case (bus.op)
                OP_NOP: ;
                OP_LOAD: begin
                    wr_do           = 1'b1;
                    wr_data         = bus.din;
                    flag_do         = 1'b1;
                    flags_nxt.zero  = is_zero(bus.din);
                    flags_nxt.carry = 1'b0;
                end
                OP_INC, OP_DEC: begin
                    wr_do           = 1'b1;
                    wr_data         = id_y;
                    flag_do         = 1'b1;
                    flags_nxt.zero  = is_zero(id_y);
                    flags_nxt.carry = id_carry;
                end
                OP_CLR: begin
                    wr_do           = 1'b1;
                    wr_data         = '0;
                    flag_do         = 1'b1;
                    flags_nxt.zero  = 1'b1;
                    flags_nxt.carry = 1'b0;
                end
                OP_SWAP: begin
`ifdef REG_BANK_SWAP_EN
                    // Swapping A with itself is a plain no-op.
                    if (bus.reg_sel != SEL_A) begin
                        swap_go = 1'b1;
                        wr_do   = 1'b1;
                        wr_idx  = SEL_A;
                        wr_data = sel_val;
                    end
`endif
                end
                default: ;
            endcase
        end
`ifdef REG_BANK_SWAP_EN
        if (state == ST_SWAP2) begin
            wr_do   = 1'b1;
            wr_idx  = swap_sel;
            wr_data = tmp;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
            flags <= '0;
        end else begin
            if (wr_do) begin
                regs[wr_idx] <= wr_data;
            end
            if (flag_do) begin
                flags <= flags_nxt;
            end
        end
    end

`ifdef REG_BANK_SWAP_EN
    // Second half of SWAP: A already holds R[sel]; tmp carries the old A back.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            tmp      <= '0;
            swap_sel <= SEL_B;
        end else begin
            state <= swap_go ? ST_SWAP2 : ST_IDLE;
            if (swap_go) begin
                tmp      <= regs[SEL_A];
                swap_sel <= bus.reg_sel;
            end
        end
    end

    assign bus.busy = (state == ST_SWAP2);
`else
    assign bus.busy = 1'b0;
`endif

    assign bus.Aout  = regs[SEL_A];
    assign bus.Bout  = regs[SEL_B];
    assign bus.Cout  = regs[SEL_C];
    assign bus.Dout  = regs[SEL_D];
    assign bus.zero  = flags.zero;
    assign bus.carry = flags.carry;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed vector table, then random commands
// against a behavioural model. Expectations follow REG_BANK_SWAP_EN.
module tb_reg_bank;

`ifdef REG_BANK_SWAP_EN
    localparam bit SWAP_ON = 1'b1;
`else
    localparam bit SWAP_ON = 1'b0;
`endif

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    reg_bank_if bus ();

    reg_bank dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string    name;
        bit       rst;
        bit       we;
        bit [2:0] op;
        bit [1:0] sel;
        bit [7:0] din;
        bit [7:0] a, b, c, d;
        bit       z, cy, busy;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: index 0..3 = B, C, D, A (the reg_sel code).
    int m_reg[4];
    bit m_z, m_c, m_busy;
    int m_tmp, m_sel;

    function automatic vec_t mk(string name, bit rst, bit we, bit [2:0] op, bit [1:0] sel,
                                bit [7:0] din, bit [7:0] a, bit [7:0] b, bit [7:0] c,
                                bit [7:0] d, bit z, bit cy, bit busy);
        vec_t v;
        v.name = name; v.rst = rst; v.we = we; v.op = op; v.sel = sel; v.din = din;
        v.a = a; v.b = b; v.c = c; v.d = d; v.z = z; v.cy = cy; v.busy = busy;
        return v;
    endfunction

    task automatic modelStep(bit rst, bit we, bit [2:0] op, int sel, int din);
        if (rst) begin
            for (int i = 0; i < 4; i++) m_reg[i] = 0;
            m_z = 0; m_c = 0; m_busy = 0; m_tmp = 0;
        end else if (m_busy) begin
            m_reg[m_sel] = m_tmp;
            m_busy = 0;
        end else if (we) begin
            case (op)
                3'd1: begin m_reg[sel] = din; m_z = (din == 0); m_c = 0; end
                3'd2: begin
                    m_c = (m_reg[sel] == 255);
                    m_reg[sel] = (m_reg[sel] + 1) % 256;
                    m_z = (m_reg[sel] == 0);
                end
                3'd3: begin
                    m_c = (m_reg[sel] == 0);
                    m_reg[sel] = (m_reg[sel] + 255) % 256;
                    m_z = (m_reg[sel] == 0);
                end
                3'd4: begin m_reg[sel] = 0; m_z = 1; m_c = 0; end
                3'd5: if (SWAP_ON && sel != 3) begin
                    m_tmp = m_reg[3];
                    m_reg[3] = m_reg[sel];
                    m_sel = sel;
                    m_busy = 1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic cmp(string name, string field, logic [7:0] got, logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s %s: got %h, want %h", name, field, got, want);
        end
    endtask

    task automatic checkOutput(string name, bit [7:0] a, bit [7:0] b, bit [7:0] c,
                               bit [7:0] d, bit z, bit cy, bit busy);
        cmp(name, "Aout", bus.Aout, a);
        cmp(name, "Bout", bus.Bout, b);
        cmp(name, "Cout", bus.Cout, c);
        cmp(name, "Dout", bus.Dout, d);
        cmp(name, "zero", {7'd0, bus.zero}, {7'd0, z});
        cmp(name, "carry", {7'd0, bus.carry}, {7'd0, cy});
        cmp(name, "busy", {7'd0, bus.busy}, {7'd0, busy});
    endtask

    // Drive one command, let one edge pass, update the model, settle before checking.
    task automatic applyStimulus(bit rst, bit we, bit [2:0] op, bit [1:0] sel, bit [7:0] din);
        reset       = rst;
        bus.wr_en   = we;
        bus.op      = op;
        bus.reg_sel = sel;
        bus.din     = din;
        @(posedge clk);
        modelStep(rst, we, op, int'(sel), int'(din));
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.wr_en = 1'b0; bus.op = 3'd0; bus.reg_sel = 2'd0; bus.din = 8'd0;

        //                 name        rst we op    sel din     A      B      C      D     z  c  busy
        vecs.push_back(mk("reset",      1, 0, 3'd0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk("load_b",     0, 1, 3'd1, 0, 8'h5A, 8'h00, 8'h5A, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk("load_c_ff",  0, 1, 3'd1, 1, 8'hFF, 8'h00, 8'h5A, 8'hFF, 8'h00, 0, 0, 0));
        vecs.push_back(mk("inc_c_wrap", 0, 1, 3'd2, 1, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 1, 1, 0));
        vecs.push_back(mk("clr_d",      0, 1, 3'd4, 2, 8'h77, 8'h00, 8'h5A, 8'h00, 8'h00, 1, 0, 0));
        vecs.push_back(mk("dec_d_wrap", 0, 1, 3'd3, 2, 8'h00, 8'h00, 8'h5A, 8'h00, 8'hFF, 0, 1, 0));
        vecs.push_back(mk("load_a",     0, 1, 3'd1, 3, 8'h11, 8'h11, 8'h5A, 8'h00, 8'hFF, 0, 0, 0));
        vecs.push_back(mk("load_d",     0, 1, 3'd1, 2, 8'h22, 8'h11, 8'h5A, 8'h00, 8'h22, 0, 0, 0));
        vecs.push_back(mk("clr_c",      0, 1, 3'd4, 1, 8'h00, 8'h11, 8'h5A, 8'h00, 8'h22, 1, 0, 0));
`ifdef REG_BANK_SWAP_EN
        vecs.push_back(mk("swap_d_1",   0, 1, 3'd5, 2, 8'h00, 8'h22, 8'h5A, 8'h00, 8'h22, 1, 0, 1));
        vecs.push_back(mk("load_busy",  0, 1, 3'd1, 0, 8'h77, 8'h22, 8'h5A, 8'h00, 8'h11, 1, 0, 0));
        vecs.push_back(mk("swap_d_2",   0, 1, 3'd5, 2, 8'h00, 8'h11, 8'h5A, 8'h00, 8'h11, 1, 0, 1));
`else
        vecs.push_back(mk("swap_d_1",   0, 1, 3'd5, 2, 8'h00, 8'h11, 8'h5A, 8'h00, 8'h22, 1, 0, 0));
        vecs.push_back(mk("load_b_77",  0, 1, 3'd1, 0, 8'h77, 8'h11, 8'h77, 8'h00, 8'h22, 0, 0, 0));
        vecs.push_back(mk("swap_d_2",   0, 1, 3'd5, 2, 8'h00, 8'h11, 8'h77, 8'h00, 8'h22, 0, 0, 0));
`endif
        vecs.push_back(mk("reset_swap2",1, 1, 3'd1, 0, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk("load_a_01",  0, 1, 3'd1, 3, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk("swap_a",     0, 1, 3'd5, 3, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk("wr_en_low",  0, 0, 3'd1, 0, 8'h99, 8'h01, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk("rsv_110",    0, 1, 3'd6, 0, 8'h99, 8'h01, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk("rsv_111",    0, 1, 3'd7, 1, 8'h99, 8'h01, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk("load_b_3c",  0, 1, 3'd1, 0, 8'h3C, 8'h01, 8'h3C, 8'h00, 8'h00, 0, 0, 0));
`ifdef REG_BANK_SWAP_EN
        vecs.push_back(mk("swap_b_1",   0, 1, 3'd5, 0, 8'h00, 8'h3C, 8'h3C, 8'h00, 8'h00, 0, 0, 1));
        vecs.push_back(mk("swap_b_2",   0, 1, 3'd0, 0, 8'h00, 8'h3C, 8'h01, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk("dec_a",      0, 1, 3'd3, 3, 8'h00, 8'h3B, 8'h01, 8'h00, 8'h00, 0, 0, 0));
`else
        vecs.push_back(mk("swap_b_1",   0, 1, 3'd5, 0, 8'h00, 8'h01, 8'h3C, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk("swap_b_2",   0, 1, 3'd0, 0, 8'h00, 8'h01, 8'h3C, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk("dec_a",      0, 1, 3'd3, 3, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 1, 0, 0));
`endif

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].op, vecs[i].sel, vecs[i].din);
            checkOutput(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d,
                        vecs[i].z, vecs[i].cy, vecs[i].busy);
        end

        // Hand sequence: two back-to-back SWAPs; the second lands in SWAP2 and is dropped.
        applyStimulus(0, 1, 3'd1, 1, 8'hA5);
        applyStimulus(0, 1, 3'd5, 1, 8'h00);
        applyStimulus(0, 1, 3'd5, 2, 8'h00);
        applyStimulus(0, 0, 3'd0, 0, 8'h00);
        checkOutput("swap_chain", 8'(m_reg[3]), 8'(m_reg[0]), 8'(m_reg[1]), 8'(m_reg[2]),
                    m_z, m_c, m_busy);
        cmp("swap_chain", "Cout_abs", bus.Cout, SWAP_ON ? 8'h3B : 8'hA5);

        for (int n = 0; n < 600; n++) begin
            bit       rst;
            bit       we;
            bit [2:0] op;
            bit [1:0] sel;
            bit [7:0] din;
            rst = ($urandom_range(0, 49) == 0);
            we  = ($urandom_range(0, 3) != 0);
            op  = 3'($urandom_range(0, 7));
            sel = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       din = 8'h00;
                1:       din = 8'hFF;
                default: din = 8'($urandom);
            endcase
            applyStimulus(rst, we, op, sel, din);
            checkOutput($sformatf("rand%0d", n), 8'(m_reg[3]), 8'(m_reg[0]), 8'(m_reg[1]),
                        8'(m_reg[2]), m_z, m_c, m_busy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
